// File: rtl/pin_pkg.sv
// Shared types and key codes for the pinPac_t keypad interface.
package pin_pkg;

    localparam int         PIN_LEN       = 4;
    localparam logic [3:0] KEY_STAR      = 4'hA;
    localparam logic [3:0] KEY_HASH      = 4'hB;
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } entry_state_t;

endpackage

// File: rtl/inactivity_timer.sv
// Idle-clock counter: runs while enabled, flags expiry on its last count.
module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Expiry itself returns the count to zero, so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!run || restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = run && (count == LAST);

endmodule

// File: rtl/pin_entry_assembler.sv
// Collects decoded key presses into a 4-digit PIN and emits a pinPac_t on '*'.
module pin_entry_assembler
    import pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output pinPac_t    pin_out,
    output logic [2:0] digit_count,
    output logic       entry_active,
    output logic       timeout_pulse
);

    entry_state_t               state;
    entry_state_t               state_next;
    logic [PIN_LEN-1:0][3:0]    buffer;   // buffer[0] holds digit1
    logic                       is_digit;
    logic                       is_star;
    logic                       is_hash;
    logic                       expire;
    logic                       timeout;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == KEY_STAR);
    assign is_hash  = key_valid && (key_code == KEY_HASH);

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state == ENTRY),
        .restart (is_digit),
        .expire  (expire)
    );

    // A meaningful key in the expiry cycle wins over the timeout.
    assign timeout = expire && !(is_digit || is_star || is_hash);

    always_comb begin
        state_next = state;
        if (is_digit) begin
            state_next = ENTRY;
        end else if (is_star || is_hash || timeout) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer        <= {PIN_LEN{DIGIT_INVALID}};
            digit_count   <= 3'd0;
            pin_out       <= {1'b0, {PIN_LEN{DIGIT_INVALID}}};
            timeout_pulse <= 1'b0;
        end else begin
            pin_out.status <= 1'b0;
            timeout_pulse  <= 1'b0;
            if (is_digit) begin
                if (digit_count < 3'(PIN_LEN)) begin
                    buffer[digit_count[1:0]] <= key_code;
                    digit_count              <= digit_count + 3'd1;
                end else begin
                    // Full buffer: drop the oldest digit, keep the last four.
                    buffer <= {key_code, buffer[PIN_LEN-1:1]};
                end
            end else if (is_star) begin
                pin_out     <= {1'b1, buffer[0], buffer[1], buffer[2], buffer[3]};
                buffer      <= {PIN_LEN{DIGIT_INVALID}};
                digit_count <= 3'd0;
            end else if (is_hash || timeout) begin
                buffer        <= {PIN_LEN{DIGIT_INVALID}};
                digit_count   <= 3'd0;
                timeout_pulse <= timeout;
            end
        end
    end

    assign entry_active = (state == ENTRY);

endmodule
